// File: rtl/ucsbece154b_branch_resolve_if.sv
// Bundle between the fetch/decode/execute datapath and the branch resolve
// block. The block itself connects through the slave modport; the pipeline
// (or a testbench) connects through the master modport.
//
// Handshake: there is no valid/ready pair on this bundle. F-stage prediction
// metadata is sampled on every rising clk edge unless StallD_i/FlushD_i say
// otherwise, and all strobes are single-cycle level pulses that the predictor
// consumes on the next rising edge.
//
// Optional feature macro: BRANCH_STATS_EN adds BranchCount_o and
// MispredictCount_o.
interface ucsbece154b_branch_resolve_if #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
);
  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

  // Fetch-side prediction metadata
  logic [31:0]             pcF_i;
  logic                    BranchTakenF_i;
  logic [31:0]             BTBtargetF_i;
  logic [NUM_GHR_BITS-1:0] PHTreadaddressF_i;

  // Hazard unit controls
  logic                    StallD_i;
  logic                    FlushD_i;
  logic                    StallE_i;
  logic                    FlushE_i;

  // Execute-stage resolution
  logic [6:0]              opE_i;
  logic                    ActualTakenE_i;
  logic [31:0]             PCTargetE_i;

  // Predictor update and redirect outputs
  logic                    BTB_we_o;
  logic [BTB_IDX_W-1:0]    BTBwriteaddress_o;
  logic [65:0]             BTBwritedata_o;
  logic                    PHTwe_o;
  logic                    PHTincrement_o;
  logic [NUM_GHR_BITS-1:0] PHTwriteaddress_o;
  logic                    GHRreset_o;
  logic                    MispredictE_o;
  logic [31:0]             PCRedirect_o;
`ifdef BRANCH_STATS_EN
  logic [31:0]             BranchCount_o;
  logic [31:0]             MispredictCount_o;
`endif

  modport master (
    output pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
    output StallD_i, FlushD_i, StallE_i, FlushE_i,
    output opE_i, ActualTakenE_i, PCTargetE_i,
    input  BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
    input  PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
    input  GHRreset_o, MispredictE_o, PCRedirect_o
`ifdef BRANCH_STATS_EN
    , input BranchCount_o, MispredictCount_o
`endif
  );

  modport slave (
    input  pcF_i, BranchTakenF_i, BTBtargetF_i, PHTreadaddressF_i,
    input  StallD_i, FlushD_i, StallE_i, FlushE_i,
    input  opE_i, ActualTakenE_i, PCTargetE_i,
    output BTB_we_o, BTBwriteaddress_o, BTBwritedata_o,
    output PHTwe_o, PHTincrement_o, PHTwriteaddress_o,
    output GHRreset_o, MispredictE_o, PCRedirect_o
`ifdef BRANCH_STATS_EN
    , output BranchCount_o, MispredictCount_o
`endif
  );
endinterface

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-stage branch resolution for the gshare/BTB predictor.
// Carries each fetched instruction's prediction metadata through the D and E
// pipeline registers, compares it against the resolved outcome in E, and
// produces BTB/PHT/GHR update strobes plus the mispredict redirect.
//
// Optional feature macro: BRANCH_STATS_EN adds 32-bit wrapping counters of
// committed control-flow instructions and of mispredicts.
module ucsbece154b_branch_resolve #(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic                         clk,
  input  logic                         reset_ni,
  ucsbece154b_branch_resolve_if.slave  bus
);

  localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic                    valid;
    logic [31:0]             pc;
    logic                    pred_taken;
    logic [31:0]             pred_target;
    logic [NUM_GHR_BITS-1:0] pht_idx;
  } stage_t;

  stage_t d_q;
  stage_t e_q;

  // F->D register: flush clears the slot, stall holds it, otherwise capture F.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      d_q <= '0;
    end else if (bus.FlushD_i) begin
      d_q <= '0;
    end else if (!bus.StallD_i) begin
      d_q.valid       <= 1'b1;
      d_q.pc          <= bus.pcF_i;
      d_q.pred_taken  <= bus.BranchTakenF_i;
      d_q.pred_target <= bus.BTBtargetF_i;
      d_q.pht_idx     <= bus.PHTreadaddressF_i;
    end
  end

  // D->E register: same flush-over-stall priority as the D stage.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      e_q <= '0;
    end else if (bus.FlushE_i) begin
      e_q <= '0;
    end else if (!bus.StallE_i) begin
      e_q <= d_q;
    end
  end

  logic        is_b;
  logic        is_j;
  logic        is_cf;
  logic        commit;
  logic        act_taken;
  logic        target_diff;
  logic        mispredict;
  logic [31:0] pc_plus4;
  logic [31:0] tag_e;

  // E-stage classification and resolution; everything is qualified by validE
  // so an empty slot (including during reset) produces no strobes.
  always_comb begin
    is_b        = e_q.valid & (bus.opE_i == OP_BRANCH);
    is_j        = e_q.valid & ((bus.opE_i == OP_JAL) | (bus.opE_i == OP_JALR));
    is_cf       = is_b | is_j;
    commit      = e_q.valid & ~bus.StallE_i;
    act_taken   = is_j | (is_b & bus.ActualTakenE_i);
    target_diff = (e_q.pred_target != bus.PCTargetE_i);
    mispredict  = commit & is_cf &
                  ((e_q.pred_taken != act_taken) | (act_taken & target_diff));
    pc_plus4    = e_q.pc + 32'd4;
    tag_e       = {{(BTB_IDX_W+2){1'b0}}, e_q.pc[31:BTB_IDX_W+2]};
  end

  // Predictor update strobes and redirect, purely combinational from E.
  always_comb begin
    bus.MispredictE_o     = mispredict;
    bus.GHRreset_o        = mispredict;
    bus.PCRedirect_o      = act_taken ? bus.PCTargetE_i : pc_plus4;
    bus.PHTwe_o           = commit & is_b;
    // Gated by is_b so the output idles at 0 when E holds no branch.
    bus.PHTincrement_o    = is_b & bus.ActualTakenE_i;
    bus.PHTwriteaddress_o = e_q.pht_idx;
    // Allocate/refresh only on a taken control-flow instruction whose
    // predicted direction or target was wrong; not-taken never allocates.
    bus.BTB_we_o          = commit & is_cf & act_taken &
                            (~e_q.pred_taken | target_diff);
    bus.BTBwriteaddress_o = e_q.pc[BTB_IDX_W+1:2];
    // Target field is zeroed with an empty E slot so idle outputs read 0.
    bus.BTBwritedata_o    = {is_b, is_j, tag_e,
                             (e_q.valid ? bus.PCTargetE_i : 32'd0)};
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q;
  logic [31:0] mispredict_count_q;

  // Committed control-flow and mispredict counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (commit & is_cf) branch_count_q <= branch_count_q + 32'd1;
      if (mispredict)     mispredict_count_q <= mispredict_count_q + 32'd1;
    end
  end

  assign bus.BranchCount_o     = branch_count_q;
  assign bus.MispredictCount_o = mispredict_count_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Self-checking bench for ucsbece154b_branch_resolve: directed scenarios from
// the branch-resolution rules followed by randomized traffic compared against
// a behavioural pipeline model.
module tb_ucsbece154b_branch_resolve;

  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] OTHER = 7'b0010011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  ucsbece154b_branch_resolve_if #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) bus ();

  ucsbece154b_branch_resolve #(.NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  // ---------------- scoreboard / model ----------------
  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          valid;
    logic [31:0] pc;
    bit          pt;
    logic [31:0] ptgt;
    logic [4:0]  idx;
  } slot_t;

  slot_t m_d, m_e;
  int unsigned m_branches = 0;
  int unsigned m_misp = 0;

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.pc = '0; s.pt = 0; s.ptgt = '0; s.idx = '0;
    return s;
  endfunction

  // Expected outcome of the instruction currently sitting in E.
  bit          x_b, x_j, x_commit, x_act, x_misp, x_btb;
  logic [31:0] x_redirect;

  task automatic model_eval();
    x_b        = m_e.valid && bus.opE_i == BR;
    x_j        = m_e.valid && (bus.opE_i == JAL || bus.opE_i == JALR);
    x_commit   = m_e.valid && !bus.StallE_i && reset_ni;
    x_act      = x_j || (x_b && bus.ActualTakenE_i);
    x_misp     = x_commit && (x_b || x_j) &&
                 ((m_e.pt != x_act) || (x_act && m_e.ptgt != bus.PCTargetE_i));
    x_btb      = x_commit && (x_b || x_j) && x_act &&
                 (!m_e.pt || m_e.ptgt != bus.PCTargetE_i);
    x_redirect = x_act ? bus.PCTargetE_i : m_e.pc + 32'd4;
  endtask

  task automatic check_outputs();
    logic [65:0] exp_data;
    model_eval();
    check_val("mispredict", bus.MispredictE_o, x_misp);
    check_val("ghr_reset",  bus.GHRreset_o,    x_misp);
    check_val("pht_we",     bus.PHTwe_o,       x_commit && x_b);
    check_val("btb_we",     bus.BTB_we_o,      x_btb);
    if (x_misp) check_val("redirect", bus.PCRedirect_o, x_redirect);
    if (x_commit && x_b) begin
      check_val("pht_inc",  bus.PHTincrement_o,    bus.ActualTakenE_i);
      check_val("pht_addr", bus.PHTwriteaddress_o, m_e.idx);
    end
    if (x_btb) begin
      exp_data = {x_b, x_j, 32'(m_e.pc / 128), bus.PCTargetE_i};
      check_val("btb_addr", bus.BTBwriteaddress_o, (m_e.pc / 4) % 32);
      check_val("btb_data", bus.BTBwritedata_o, exp_data);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock: update the model with the inputs present at the edge,
  // then return at the following falling edge for the next drive.
  task automatic tick();
    slot_t nd, ne;
    @(posedge clk);
    model_eval();
    if (!reset_ni) begin
      m_d = empty_slot();
      m_e = empty_slot();
      m_branches = 0;
      m_misp = 0;
    end else begin
      if (x_commit && (x_b || x_j)) m_branches++;
      if (x_misp) m_misp++;
      ne = bus.FlushE_i ? empty_slot() : (bus.StallE_i ? m_e : m_d);
      if (bus.FlushD_i) nd = empty_slot();
      else if (bus.StallD_i) nd = m_d;
      else begin
        nd.valid = 1; nd.pc = bus.pcF_i; nd.pt = bus.BranchTakenF_i;
        nd.ptgt = bus.BTBtargetF_i; nd.idx = bus.PHTreadaddressF_i;
      end
      m_d = nd;
      m_e = ne;
    end
    @(negedge clk);
  endtask

  task automatic set_f(input logic [31:0] pc, input bit pt,
                       input logic [31:0] ptgt, input logic [4:0] idx);
    bus.pcF_i = pc; bus.BranchTakenF_i = pt;
    bus.BTBtargetF_i = ptgt; bus.PHTreadaddressF_i = idx;
  endtask

  // Feed one instruction through F and D so it sits in E afterwards.
  task automatic load_e(input logic [31:0] pc, input bit pt,
                        input logic [31:0] ptgt, input logic [4:0] idx);
    bus.StallD_i = 0; bus.FlushD_i = 0; bus.StallE_i = 0; bus.FlushE_i = 0;
    set_f(pc, pt, ptgt, idx);
    tick();
    bus.opE_i = OTHER;
    set_f(pc + 32'd4, 0, 32'd0, 5'd0);
    tick();
  endtask

  task automatic do_reset();
    reset_ni = 0;
    tick();
    tick();
    reset_ni = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    m_d = empty_slot();
    m_e = empty_slot();
    set_f(32'd0, 0, 32'd0, 5'd0);
    bus.StallD_i = 0; bus.FlushD_i = 0; bus.StallE_i = 0; bus.FlushE_i = 0;
    bus.opE_i = OTHER; bus.ActualTakenE_i = 0; bus.PCTargetE_i = 32'd0;

    #1;
    check_val("rst_misp",     bus.MispredictE_o, 0);
    check_val("rst_btb_we",   bus.BTB_we_o, 0);
    check_val("rst_pht_we",   bus.PHTwe_o, 0);
    check_val("rst_redirect", bus.PCRedirect_o, 32'd4);
    @(negedge clk);
    do_reset();

    // Cold taken branch
    load_e(32'h40, 0, 32'h0, 5'd3);
    bus.opE_i = BR; bus.ActualTakenE_i = 1; bus.PCTargetE_i = 32'h20;
    #1;
    check_outputs();
    check_val("cold_misp",     bus.MispredictE_o, 1);
    check_val("cold_redirect", bus.PCRedirect_o, 32'h20);
    check_val("cold_btb_we",   bus.BTB_we_o, 1);
    check_val("cold_btb_addr", bus.BTBwriteaddress_o, 16);
    check_val("cold_btb_data", bus.BTBwritedata_o, {2'b10, 32'h0, 32'h20});
    check_val("cold_pht_we",   bus.PHTwe_o, 1);
    check_val("cold_pht_inc",  bus.PHTincrement_o, 1);

    // Correct not-taken branch
    load_e(32'h80, 0, 32'h0, 5'd9);
    bus.opE_i = BR; bus.ActualTakenE_i = 0; bus.PCTargetE_i = 32'h90;
    #1;
    check_outputs();
    check_val("nt_misp",    bus.MispredictE_o, 0);
    check_val("nt_btb_we",  bus.BTB_we_o, 0);
    check_val("nt_pht_we",  bus.PHTwe_o, 1);
    check_val("nt_pht_inc", bus.PHTincrement_o, 0);

    // jalr with a changed target
    load_e(32'h300, 1, 32'h100, 5'd7);
    bus.opE_i = JALR; bus.ActualTakenE_i = 0; bus.PCTargetE_i = 32'h200;
    #1;
    check_outputs();
    check_val("jalr_misp",     bus.MispredictE_o, 1);
    check_val("jalr_redirect", bus.PCRedirect_o, 32'h200);
    check_val("jalr_btb_we",   bus.BTB_we_o, 1);
    check_val("jalr_btb_data", bus.BTBwritedata_o, {2'b01, 32'h6, 32'h200});
    check_val("jalr_pht_we",   bus.PHTwe_o, 0);

    // Fall-through redirect wraps at 2^32
    load_e(32'hFFFF_FFFC, 1, 32'h10, 5'd1);
    bus.opE_i = BR; bus.ActualTakenE_i = 0; bus.PCTargetE_i = 32'h10;
    #1;
    check_outputs();
    check_val("wrap_redirect", bus.PCRedirect_o, 32'h0);

    // Aliased BTB hit on a non-control-flow opcode
    load_e(32'h444, 1, 32'h888, 5'd2);
    bus.opE_i = OTHER; bus.ActualTakenE_i = 1; bus.PCTargetE_i = 32'h0;
    #1;
    check_outputs();
    check_val("alias_misp", bus.MispredictE_o, 0);
    check_val("alias_btb",  bus.BTB_we_o, 0);

    // Stall E three cycles on a taken branch: exactly one PHT pulse
    load_e(32'h500, 0, 32'h0, 5'd4);
    bus.opE_i = BR; bus.ActualTakenE_i = 1; bus.PCTargetE_i = 32'h600;
    bus.StallE_i = 1; bus.StallD_i = 1;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_outputs();
      check_val("stall_pht_we", bus.PHTwe_o, 0);
      pulses += int'(bus.PHTwe_o);
      tick();
    end
    bus.StallE_i = 0; bus.StallD_i = 0;
    #1;
    check_outputs();
    check_val("release_pht_we", bus.PHTwe_o, 1);
    pulses += int'(bus.PHTwe_o);
    tick();
    bus.opE_i = OTHER;
    #1;
    pulses += int'(bus.PHTwe_o);
    check_val("stall_pulses", pulses, 1);

    // Flush with stall empties E: no pulse
    load_e(32'h540, 0, 32'h0, 5'd5);
    bus.opE_i = BR; bus.ActualTakenE_i = 1; bus.PCTargetE_i = 32'h700;
    bus.StallE_i = 1; bus.FlushE_i = 1;
    #1;
    check_val("fs_stalled_pht", bus.PHTwe_o, 0);
    tick();
    bus.StallE_i = 0; bus.FlushE_i = 0;
    #1;
    check_outputs();
    check_val("fs_pht_we", bus.PHTwe_o, 0);
    check_val("fs_misp",   bus.MispredictE_o, 0);

    // Asynchronous reset with a live mispredicting branch in E
    load_e(32'h640, 0, 32'h0, 5'd6);
    bus.opE_i = BR; bus.ActualTakenE_i = 1; bus.PCTargetE_i = 32'h20;
    #1;
    check_val("pre_rst_misp", bus.MispredictE_o, 1);
    reset_ni = 0;
    m_d = empty_slot();
    m_e = empty_slot();
    #1;
    check_val("arst_misp",     bus.MispredictE_o, 0);
    check_val("arst_btb_we",   bus.BTB_we_o, 0);
    check_val("arst_pht_we",   bus.PHTwe_o, 0);
    check_val("arst_ghr",      bus.GHRreset_o, 0);
    check_val("arst_pht_inc",  bus.PHTincrement_o, 0);
    check_val("arst_btb_data", bus.BTBwritedata_o, 66'd0);
    check_val("arst_redirect", bus.PCRedirect_o, 32'd4);
    @(negedge clk);
    do_reset();

`ifdef BRANCH_STATS_EN
    // Ten committed branches, first three mispredicted
    for (int i = 0; i < 10; i++) begin
      load_e(32'h1000 + 32'(i * 16), 0, 32'h0, 5'(i));
      bus.opE_i = BR; bus.ActualTakenE_i = (i < 3); bus.PCTargetE_i = 32'h300;
    end
    tick();
    bus.opE_i = OTHER;
    #1;
    check_val("branch_count", bus.BranchCount_o, 10);
    check_val("misp_count",   bus.MispredictCount_o, 3);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      set_f(32'($urandom) & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
            32'($urandom) & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)));
      bus.StallD_i = ($urandom_range(0, 7) == 0);
      bus.FlushD_i = ($urandom_range(0, 9) == 0);
      bus.StallE_i = ($urandom_range(0, 7) == 0);
      bus.FlushE_i = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 4))
        0, 1:    bus.opE_i = BR;
        2:       bus.opE_i = JAL;
        3:       bus.opE_i = JALR;
        default: bus.opE_i = 7'($urandom_range(0, 127));
      endcase
      bus.ActualTakenE_i = 1'($urandom_range(0, 1));
      bus.PCTargetE_i = ($urandom_range(0, 1) == 1) ? m_e.ptgt
                                                    : (32'($urandom) & 32'hFFFF_FFFC);
      #1;
      check_outputs();
      tick();
    end

`ifdef BRANCH_STATS_EN
    #1;
    check_val("rand_branch_count", bus.BranchCount_o, m_branches);
    check_val("rand_misp_count",   bus.MispredictCount_o, m_misp);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_branch_resolve.md
# ucsbece154b_branch_resolve

Execute-stage companion to the gshare/BTB predictor. Carries each fetched instruction's prediction metadata (predicted direction, predicted target, PHT index) through the D and E pipeline registers. In E it compares the prediction against the resolved outcome and generates the BTB/PHT/GHR update strobes and the mispredict redirect that the predictor and the fetch PC mux consume.

## Interface
- NUM_BTB_ENTRIES, 32, BTB depth; index is pc[$clog2(N)+1:2], tag is pc[31:$clog2(N)+2] zero-extended to 32 bits
- NUM_GHR_BITS, 5, PHT index width
- clk  in  1  single clock, all state on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- pcF_i  in  32  fetch PC
- BranchTakenF_i  in  1  predictor direction for pcF_i
- BTBtargetF_i  in  32  predictor target for pcF_i
- PHTreadaddressF_i  in  NUM_GHR_BITS  PHT index used for pcF_i
- StallD_i, FlushD_i, StallE_i, FlushE_i  in  1 each  hazard-unit controls
- opE_i  in  7  opcode of the instruction in E
- ActualTakenE_i  in  1  branch condition result; ignored for jal/jalr
- PCTargetE_i  in  32  resolved target (branch/jal/jalr)
- BTB_we_o  out  1  BTB write strobe
- BTBwriteaddress_o  out  $clog2(NUM_BTB_ENTRIES)  BTB index of pcE
- BTBwritedata_o  out  66  {B, J, tag[31:0], target[31:0]}
- PHTwe_o, PHTincrement_o  out  1 each  PHT update strobe and direction
- PHTwriteaddress_o  out  NUM_GHR_BITS  carried PHT index
- GHRreset_o  out  1  clears GHR on mispredict
- MispredictE_o  out  1  redirect request
- PCRedirect_o  out  32  correct next PC

## Operation
- D and E registers, each holding {valid, pc, predTaken, predTarget, phtIdx}.
- F->D: FlushD_i clears valid; else StallD_i holds; else load F inputs with valid=1. Same rule for D->E using FlushE_i/StallE_i. Flush beats stall.
- E classification (only when validE): isB = opE_i==branch op; isJ = jal or jalr. Otherwise no strobes are asserted.
- Commit = validE & !StallE_i. All strobes are gated by commit, so each instruction updates exactly once.
- actTaken = isJ | (isB & ActualTakenE_i).
- Mispredict = commit & (isB|isJ) & ((predTaken != actTaken) | (actTaken & predTarget != PCTargetE_i)).
- PCRedirect_o = actTaken ? PCTargetE_i : pcE+4, computed mod 2^32 (0xFFFFFFFC+4 = 0). Value is don't-care when MispredictE_o=0.
- GHRreset_o = MispredictE_o.
- PHTwe_o = commit & isB; PHTincrement_o = ActualTakenE_i; PHTwriteaddress_o = phtIdx.
- BTB_we_o = commit & (isB|isJ) & actTaken & (!predTaken | predTarget != PCTargetE_i).
- BTBwritedata_o = {isB, isJ, tag(pcE), PCTargetE_i}. Not-taken branches never allocate.
- Non-control-flow opcodes in E produce all strobes 0, even if predTaken=1 (an aliased BTB hit is tolerated).

## Timing
- Reset (async assert, sync release): validD=validE=0, all payloads 0. All outputs read 0 except PCRedirect_o, which reads 4 (pcE=0, actTaken=0).
- Prediction for an instruction is visible at E outputs 2 cycles after it is sampled in F, absent stalls.
- All outputs are combinational from E registers plus E inputs. Predictor updates land on the next edge.
- Mispredict in E: the hazard unit asserts FlushD_i/FlushE_i in that cycle, so the wrong-path instructions never commit.
- Reset mid-stall clears both stages immediately. No strobe fires in the cycle reset_ni is low.

## Configuration
- BRANCH_STATS_EN defined: adds outputs BranchCount_o[31:0] (increments on commit & (isB|isJ)) and MispredictCount_o[31:0] (increments on MispredictE_o). Both wrap at 2^32 and reset to 0.
- BRANCH_STATS_EN undefined: ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset then idle: reset_ni=0 mid-run with validE=1 -> all strobes 0 immediately, PCRedirect_o=4.
- Cold taken branch: pc=0x40, predTaken=0, ActualTaken=1, target=0x20 -> MispredictE_o=1, PCRedirect_o=0x20, BTB_we_o=1, BTBwriteaddress_o=16, data={1,0,0x0,0x20}, PHTwe_o=1, PHTincrement_o=1.
- Correct not-taken branch: predTaken=0, ActualTaken=0 at pc=0x80 -> MispredictE_o=0, BTB_we_o=0, PHTwe_o=1, PHTincrement_o=0.
- jalr target change: predTaken=1, predTarget=0x100, PCTargetE_i=0x200 -> MispredictE_o=1, PCRedirect_o=0x200, BTB_we_o=1 with J=1, PHTwe_o=0.
- StallE_i held 3 cycles on a taken branch -> strobes 0 while stalled, exactly one PHTwe_o pulse on release; FlushE_i with StallE_i -> validE=0, no pulse.
- With BRANCH_STATS_EN: 10 branches, 3 mispredicted -> BranchCount_o=10, MispredictCount_o=3.
